// File: rtl/fb_pkg.sv
// Shared types for the pixel-plot framebuffer and the drawing engines'
// checker: geometry, controller states and the queued plot entry.
package fb_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_PIXELS = FB_W * FB_H;
    localparam int AW        = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        DONE  = 3'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    colour;
    } plot_t;

    function automatic logic [AW-1:0] fb_addr(
        input logic [7:0]    x,
        input logic [6:0]    y,
        input logic [AW-1:0] w
    );
        return {8'd0, y} * w + {7'd0, x};
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO; a pop in the same cycle frees a slot for a push
// into a full buffer, and drop flags a push that could not be taken.
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = store[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wp] <= din;
    end

endmodule

// File: rtl/plot_framebuffer.sv
// Plot receiver: filters and queues engine plots, commits them to a
// 160x120x3 framebuffer, runs a full-screen clear and serves a read port.
module plot_framebuffer #(
    parameter int         FB_W         = fb_pkg::FB_W,
    parameter int         FB_H         = fb_pkg::FB_H,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_start,
    output logic        clear_done,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic [2:0]  rd_colour,
    output logic        overflow,
    output logic        oob,
    output logic [15:0] wr_count
);

    import fb_pkg::*;

    localparam int            PIXELS = FB_W * FB_H;
    localparam logic [7:0]    W8     = 8'(FB_W);
    localparam logic [6:0]    H7     = 7'(FB_H);
    localparam logic [AW-1:0] W15    = AW'(FB_W);
    localparam logic [AW-1:0] LAST   = AW'(PIXELS - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_addr;

    plot_t         in_entry;
    plot_t         head;
    logic          in_range;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          drop;

    logic          we;
    logic [AW-1:0] waddr;
    logic [2:0]    wdata;
    logic [2:0]    mem [PIXELS];

    logic          rd_in;
    logic [AW-1:0] rd_addr;

    assign in_range = (vga_x < W8) && (vga_y < H7);
    assign push     = vga_plot && in_range;
    assign in_entry = '{addr: fb_addr(vga_x, vga_y, W15), colour: vga_colour};
    assign pop      = !empty && (state != CLEAR);

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(plot_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    // Clear owns the write port; queued plots wait until it finishes.
    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = head.addr;
        wdata      = head.colour;
        unique case (state)
            IDLE: begin
                if (clear_start) state_next = CLEAR;
                we = pop;
            end
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_addr;
                wdata = CLEAR_COLOUR;
                if (clr_addr == LAST) state_next = DONE;
            end
            DONE: begin
                if (!clear_start) state_next = IDLE;
                we = pop;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_addr   <= '0;
            clear_done <= 1'b0;
            overflow   <= 1'b0;
            oob        <= 1'b0;
            wr_count   <= '0;
        end else begin
            state      <= state_next;
            clear_done <= (state_next == DONE);
            if (state == IDLE && clear_start)
                clr_addr <= '0;
            else if (state == CLEAR)
                clr_addr <= clr_addr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            if (vga_plot && !in_range)
                oob <= 1'b1;
            if (pop && wr_count != 16'hFFFF)
                wr_count <= wr_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rd_in   = (rd_x < W8) && (rd_y < H7);
    assign rd_addr = fb_addr(rd_x, rd_y, W15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_colour <= '0;
        else
            rd_colour <= rd_in ? mem[rd_addr] : 3'd0;
    end

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer: clear, plot, filter, overflow,
// read-first and reset-during-clear behaviour.
module tb_plot_framebuffer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic        clear_done;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [2:0]  rd_colour;
    logic        overflow;
    logic        oob;
    logic [15:0] wr_count;

    int checks;
    int failures;

    plot_framebuffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .clear_start (clear_start),
        .clear_done  (clear_done),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_colour   (rd_colour),
        .overflow    (overflow),
        .oob         (oob),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] c);
        vga_x      = x;
        vga_y      = y;
        vga_colour = c;
        vga_plot   = 1'b1;
        @(negedge clk);
        vga_plot   = 1'b0;
    endtask

    task automatic check_px(input string tag, input logic [7:0] x,
                            input logic [6:0] y, input logic [2:0] exp);
        rd_x = x;
        rd_y = y;
        tick(2);
        check(tag, 32'(rd_colour), 32'(exp));
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (clear_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        vga_x       = '0;
        vga_y       = '0;
        vga_colour  = '0;
        vga_plot    = 1'b0;
        clear_start = 1'b0;
        rd_x        = '0;
        rd_y        = '0;
        tick(3);
        check("rst_done", 32'(clear_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_oob", 32'(oob), 32'd0);
        check("rst_wc", 32'(wr_count), 32'd0);
        check("rst_rd", 32'(rd_colour), 32'd0);
        rst_n = 1'b1;
        tick(1);

        plot(8'd0, 7'd0, 3'd7);
        plot(8'd159, 7'd119, 3'd6);
        check_px("pre_00", 8'd0, 7'd0, 3'd7);
        check_px("pre_max", 8'd159, 7'd119, 3'd6);
        check("pre_wc", 32'(wr_count), 32'd2);

        clear_start = 1'b1;
        tick(19200);
        check("clr_early", 32'(clear_done), 32'd0);
        tick(1);
        check("clr_done", 32'(clear_done), 32'd1);
        clear_start = 1'b0;
        tick(1);
        check("clr_drop", 32'(clear_done), 32'd0);
        check_px("clr_00", 8'd0, 7'd0, 3'd0);
        check_px("clr_max", 8'd159, 7'd119, 3'd0);
        check_px("clr_mid", 8'd80, 7'd60, 3'd0);
        check("clr_wc", 32'(wr_count), 32'd2);

        plot(8'd40, 7'd80, 3'd5);
        check_px("px_40_80", 8'd40, 7'd80, 3'd5);
        check("px_wc", 32'(wr_count), 32'd3);

        plot(8'd1, 7'd1, 3'd3);
        rd_x = 8'd1;
        rd_y = 7'd1;
        tick(1);
        check("rd_first_old", 32'(rd_colour), 32'd0);
        tick(1);
        check("rd_first_new", 32'(rd_colour), 32'd3);

        plot(8'd0, 7'd1, 3'd6);
        check_px("px_0_1", 8'd0, 7'd1, 3'd6);
        check("oob_pre", 32'(oob), 32'd0);
        plot(8'd160, 7'd10, 3'd7);
        plot(8'd10, 7'd120, 3'd7);
        check("oob_set", 32'(oob), 32'd1);
        check_px("oob_0_10", 8'd0, 7'd10, 3'd0);
        check_px("oob_0_11", 8'd0, 7'd11, 3'd0);
        check("oob_wc", 32'(wr_count), 32'd5);
        check_px("rd_oob", 8'd160, 7'd0, 3'd0);

        clear_start = 1'b1;
        tick(1);
        check("ovf_pre", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++)
            plot(8'(2 + i), 7'd2, 3'(i + 1));
        clear_start = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        wait_done("ovf_done");
        tick(6);
        check("ovf_idle", 32'(clear_done), 32'd0);
        for (int i = 0; i < 4; i++)
            check_px($sformatf("ovf_keep%0d", i), 8'(2 + i), 7'd2, 3'(i + 1));
        check_px("ovf_lost4", 8'd6, 7'd2, 3'd0);
        check_px("ovf_lost5", 8'd7, 7'd2, 3'd0);
        check_px("ovf_clr", 8'd40, 7'd80, 3'd0);
        check("ovf_wc", 32'(wr_count), 32'd9);

        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("b2b_rst_ovf", 32'(overflow), 32'd0);
        check("b2b_rst_wc", 32'(wr_count), 32'd0);
        for (int i = 0; i < 10; i++) begin
            vga_x      = 8'(10 + i);
            vga_y      = 7'd50;
            vga_colour = 3'((i % 7) + 1);
            vga_plot   = 1'b1;
            tick(1);
        end
        vga_plot = 1'b0;
        tick(2);
        check("b2b_ovf", 32'(overflow), 32'd0);
        check("b2b_wc", 32'(wr_count), 32'd10);
        for (int i = 0; i < 10; i++)
            check_px($sformatf("b2b%0d", i), 8'(10 + i), 7'd50,
                     3'((i % 7) + 1));

        clear_start = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++)
            plot(8'(20 + i), 7'd5, 3'd7);
        plot(8'd200, 7'd0, 3'd1);
        tick(92);
        check("mid_ovf", 32'(overflow), 32'd1);
        check("mid_oob", 32'(oob), 32'd1);
        check("mid_busy", 32'(clear_done), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_done", 32'(clear_done), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_oob", 32'(oob), 32'd0);
        check("mid_rst_wc", 32'(wr_count), 32'd0);
        clear_start = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_px("mid_partial", 8'd10, 7'd50, 3'd1);
        check_px("mid_dropq", 8'd20, 7'd5, 3'd0);
        check("mid_wc0", 32'(wr_count), 32'd0);
        plot(8'd30, 7'd30, 3'd4);
        check_px("mid_idle_px", 8'd30, 7'd30, 3'd4);
        check("mid_wc1", 32'(wr_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plot_framebuffer.md
Name: plot_framebuffer

Overview:
- Receiver end of the pixel-plot interface driven by the drawing engines (circle, reuleaux, fill).
- Accepts `vga_x`/`vga_y`/`vga_colour`/`vga_plot` strobes and buffers them in a small FIFO.
- Commits them into an on-chip 160x120x3 framebuffer.
- Provides a clear engine with start/done handshake, and a synchronous read port for scan-out or checking.

Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- FIFO_DEPTH, 4, plot buffer entries (power of two, >=2)
- CLEAR_COLOUR, 3'b000, colour written by clear engine

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  3  plot colour
- vga_plot  in  1  plot strobe, one pixel per cycle when high
- clear_start  in  1  level request to clear framebuffer
- clear_done  out  1  clear complete, held while clear_start high
- rd_x  in  8  read port x
- rd_y  in  7  read port y
- rd_colour  out  3  pixel at (rd_x,rd_y), 1-cycle latency
- overflow  out  1  sticky: in-range plot dropped because FIFO full
- oob  out  1  sticky: plot with x>=FB_W or y>=FB_H seen
- wr_count  out  16  pixels committed to memory (saturating)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; FIFO empty.
  - `clear_done`=0, `overflow`=0, `oob`=0, `wr_count`=0, `rd_colour`=0.
  - Memory contents are not reset (undefined until cleared).
- Address rule: addr = y*FB_W + x, 15 bits.
- Input filter, evaluated each cycle:
  - If `vga_plot`=1 and (x>=FB_W or y>=FB_H): discard, set `oob`.
  - Otherwise, if `vga_plot`=1, enqueue {addr,colour}.
- FIFO:
  - Enqueue when full: drop the plot and set `overflow`. Exception: a dequeue in the same cycle frees a slot, so enqueue succeeds with no overflow.
  - Simultaneous enqueue and dequeue leaves occupancy unchanged.
- State machine (3-bit state):
  - IDLE:
    - Drain one FIFO entry per cycle into memory.
    - `clear_start`=1 -> CLEAR; clear address counter set to 0.
  - CLEAR:
    - Write CLEAR_COLOUR at counter address each cycle, counter++.
    - FIFO is not drained; plots still enqueue (and may overflow).
    - After writing address FB_W*FB_H-1 (19199) -> DONE.
    - Duration: exactly 19200 cycles.
  - DONE:
    - `clear_done`=1 (registered); FIFO drains again.
    - `clear_start`=0 -> IDLE and `clear_done`=0 next cycle.
  - `clear_start` dropped mid-CLEAR is ignored; the clear runs to completion.
- Commit latency: a plot strobed at edge N while the FIFO is empty and the engine is not in CLEAR is written to memory at edge N+1.
- Plots queued before a clear commit after the clear completes, so they survive it.
- `wr_count`:
  - Increments per FIFO commit only; clear writes are not counted.
  - Saturates at 16'hFFFF.
- Read port:
  - `rd_colour` registered from addr(`rd_x`,`rd_y`).
  - Read-first: a same-cycle write to the same address returns the old data.
  - Out-of-range read address returns 0.
- Reset mid-CLEAR: returns to IDLE immediately; partially cleared memory is left as is.

Decomposition:
- Shared package `fb_pkg`:
  - FB_W, FB_H, FB_PIXELS=19200, address width 15.
  - State enum {IDLE, CLEAR, DONE}.
  - Plot-entry struct {addr[14:0], colour[2:0]}; reused by the drawing engines' checker.
- One sub-module, `plot_fifo`: parameterised synchronous FIFO with full/empty and push/pop in the same cycle.
- Memory inferred in the top level as a simple dual-port RAM.

Test Plan:
- Reset then assert `clear_start` -> `clear_done`=1 after 19200+1 cycles; reading (0,0), (159,119) and (80,60) gives 0; `wr_count`=0.
- After clear, plot (40,80) colour 3'b101 for one cycle, then read (40,80) two cycles later -> `rd_colour`=5; `wr_count`=1.
- Plot (160,10) and (10,120) -> `oob`=1, memory unchanged at (0,10), `wr_count` unchanged.
- During CLEAR, plot 6 in-range pixels on consecutive cycles -> first 4 buffered, `overflow`=1; after DONE those 4 pixels read back with their colours; `wr_count`=4.
- Back-to-back plots of 10 distinct pixels in IDLE -> no overflow; all 10 read back correctly; `wr_count`=10.
- Assert `rst_n`=0 at cycle 100 of CLEAR -> state IDLE, `clear_done`=0, `overflow`=0, `wr_count`=0 immediately.
